// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS sequencer: Moore FSM driving datapath selects/enables, counts retirements, halts on bad encodings.
// Outputs registered from next state; only mem_ready->ir_write/pc_en, zero->pc_en, funct->alu_control are combinational; stalls in FETCH/MEM_READ/MEM_WRITE.
module mips_multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic [1:0]  pc_source,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic [3:0]  state,
    output logic        halted,
    output logic [31:0] instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t      r_state;
    logic [31:0] r_instr_retired;
    logic        r_fetch;
    logic        r_branch;
    logic        r_jump;
    logic [1:0]  r_pc_source;
    logic        r_i_or_d;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_reg_dst;
    logic        r_mem_to_reg;
    logic        r_reg_write;
    logic        r_alu_src_a;
    logic [1:0]  r_alu_src_b;
    logic [1:0]  r_alu_op;
    logic        r_halted;

    state_t      w_next;
    state_t      w_ctl_state;
    logic        w_funct_ok;
    logic        w_retire;

    always_comb begin
        case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_funct_ok = 1'b1;
            default:                                               w_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = w_funct_ok ? S_EXECUTE : S_HALT;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   w_next = S_R_WB;
            S_ADDI_EX:   w_next = S_ADDI_WB;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (r_state)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_retire = 1'b1;
            S_MEM_WRITE:                                  w_retire = mem_ready;
            default:                                      w_retire = 1'b0;
        endcase
    end

    // Output registers are loaded with the decode of the state being entered.
    assign w_ctl_state = reset ? S_FETCH : w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_FETCH;
            r_instr_retired <= '0;
        end else begin
            r_state         <= w_next;
            r_instr_retired <= r_instr_retired + {31'd0, w_retire};
        end
        r_fetch      <= 1'b0;
        r_branch     <= 1'b0;
        r_jump       <= 1'b0;
        r_pc_source  <= 2'b00;
        r_i_or_d     <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_reg_dst    <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_reg_write  <= 1'b0;
        r_alu_src_a  <= 1'b0;
        r_alu_src_b  <= 2'b00;
        r_alu_op     <= 2'b00;
        r_halted     <= 1'b0;
        case (w_ctl_state)
            S_FETCH: begin
                r_fetch     <= 1'b1;
                r_mem_read  <= 1'b1;
                r_alu_src_b <= 2'b01;
            end
            S_DECODE:    r_alu_src_b <= 2'b11;
            S_MEM_ADDR, S_ADDI_EX: begin
                r_alu_src_a <= 1'b1;
                r_alu_src_b <= 2'b10;
            end
            S_MEM_READ: begin
                r_mem_read <= 1'b1;
                r_i_or_d   <= 1'b1;
            end
            S_MEM_WB: begin
                r_reg_write  <= 1'b1;
                r_mem_to_reg <= 1'b1;
            end
            S_MEM_WRITE: begin
                r_mem_write <= 1'b1;
                r_i_or_d    <= 1'b1;
            end
            S_EXECUTE: begin
                r_alu_src_a <= 1'b1;
                r_alu_op    <= 2'b10;
            end
            S_R_WB: begin
                r_reg_write <= 1'b1;
                r_reg_dst   <= 1'b1;
            end
            S_BRANCH: begin
                r_branch    <= 1'b1;
                r_alu_src_a <= 1'b1;
                r_alu_op    <= 2'b01;
                r_pc_source <= 2'b01;
            end
            S_JUMP: begin
                r_jump      <= 1'b1;
                r_pc_source <= 2'b10;
            end
            S_ADDI_WB:   r_reg_write <= 1'b1;
            S_HALT:      r_halted    <= 1'b1;
            default:     r_fetch     <= 1'b0;
        endcase
    end

    always_comb begin
        alu_control = 4'b0000;
        case (r_alu_op)
            2'b01: alu_control = 4'b0001;
            2'b10: begin
                case (funct)
                    6'b100010: alu_control = 4'b0001;
                    6'b100100: alu_control = 4'b0010;
                    6'b100101: alu_control = 4'b0011;
                    6'b101010: alu_control = 4'b0100;
                    default:   alu_control = 4'b0000;
                endcase
            end
            default: alu_control = 4'b0000;
        endcase
    end

    assign ir_write      = r_fetch & mem_ready;
    assign pc_en         = (r_fetch & mem_ready) | (r_branch & zero) | r_jump;
    assign pc_source     = r_pc_source;
    assign i_or_d        = r_i_or_d;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign reg_dst       = r_reg_dst;
    assign mem_to_reg    = r_mem_to_reg;
    assign reg_write     = r_reg_write;
    assign alu_src_a     = r_alu_src_a;
    assign alu_src_b     = r_alu_src_b;
    assign state         = r_state;
    assign halted        = r_halted;
    assign instr_retired = r_instr_retired;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized instruction streams checked cycle by cycle against an instruction-level model of the sequencer.
module tb_mips_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_en;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic [3:0]  state;
    logic        halted;
    logic [31:0] instr_retired;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_source(pc_source), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .state(state), .halted(halted),
        .instr_retired(instr_retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEM_ADDR = 2, P_MEM_READ = 3, P_MEM_WB = 4,
                   P_MEM_WRITE = 5, P_EXECUTE = 6, P_R_WB = 7, P_BRANCH = 8, P_JUMP = 9,
                   P_ADDI_EX = 10, P_ADDI_WB = 11, P_HALT = 15;
    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] asb;
        logic [3:0] aluc;
        logic       halted;
    } obs_t;

    typedef struct {
        obs_t        o;
        logic [31:0] ret;
        int          ph;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_ret;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_cyc = 0;

    function automatic logic [3:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'd1;
            6'h24:   return 4'd2;
            6'h25:   return 4'd3;
            6'h2A:   return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) ? K_R : K_ILL;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h08:   return K_ADDI;
            default: return K_ILL;
        endcase
    endfunction

    // What the datapath must see while the instruction is in a given phase.
    function automatic obs_t expect_for(input int ph, input logic mr, input logic z, input logic [5:0] fn);
        obs_t e;
        e = '0;
        e.st = 4'(ph);
        case (ph)
            P_FETCH:     begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pc_en = mr; end
            P_DECODE:    e.asb = 2'b11;
            P_MEM_ADDR:  begin e.asa = 1; e.asb = 2'b10; end
            P_MEM_READ:  begin e.mrd = 1; e.iord = 1; end
            P_MEM_WB:    begin e.rw = 1; e.m2r = 1; end
            P_MEM_WRITE: begin e.mwr = 1; e.iord = 1; end
            P_EXECUTE:   begin e.asa = 1; e.aluc = ref_alu(fn); end
            P_R_WB:      begin e.rw = 1; e.rdst = 1; end
            P_BRANCH:    begin e.asa = 1; e.aluc = 4'd1; e.pc_src = 2'b01; e.pc_en = z; end
            P_JUMP:      begin e.pc_src = 2'b10; e.pc_en = 1; end
            P_ADDI_EX:   begin e.asa = 1; e.asb = 2'b10; end
            P_ADDI_WB:   e.rw = 1;
            P_HALT:      e.halted = 1;
            default:     e = '0;
        endcase
        return e;
    endfunction

    task automatic cyc(input int ph, input logic mr, input logic z, input logic rst, input bit retires);
        exp_t e;
        mem_ready = mr;
        zero      = z;
        reset     = rst;
        e.o   = expect_for(ph, mr, z, funct);
        e.ret = m_ret;
        e.ph  = ph;
        q.push_back(e);
        @(posedge clk);
        #1;
        n_cyc++;
        if (rst) m_ret = '0;
        else if (retires) m_ret = m_ret + 32'd1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int w_fetch, input int w_mem, input int halt_len);
        int k;
        opcode = op;
        funct  = fn;
        k = classify(op, fn);
        repeat (w_fetch) cyc(P_FETCH, 1'b0, rb(), 1'b0, 1'b0);
        cyc(P_FETCH, 1'b1, rb(), 1'b0, 1'b0);
        cyc(P_DECODE, rb(), rb(), 1'b0, 1'b0);
        case (k)
            K_R: begin
                cyc(P_EXECUTE, rb(), rb(), 1'b0, 1'b0);
                cyc(P_R_WB, rb(), rb(), 1'b0, 1'b1);
            end
            K_LW: begin
                cyc(P_MEM_ADDR, rb(), rb(), 1'b0, 1'b0);
                repeat (w_mem) cyc(P_MEM_READ, 1'b0, rb(), 1'b0, 1'b0);
                cyc(P_MEM_READ, 1'b1, rb(), 1'b0, 1'b0);
                cyc(P_MEM_WB, rb(), rb(), 1'b0, 1'b1);
            end
            K_SW: begin
                cyc(P_MEM_ADDR, rb(), rb(), 1'b0, 1'b0);
                repeat (w_mem) cyc(P_MEM_WRITE, 1'b0, rb(), 1'b0, 1'b0);
                cyc(P_MEM_WRITE, 1'b1, rb(), 1'b0, 1'b1);
            end
            K_BEQ:  cyc(P_BRANCH, rb(), z, 1'b0, 1'b1);
            K_J:    cyc(P_JUMP, rb(), rb(), 1'b0, 1'b1);
            K_ADDI: begin
                cyc(P_ADDI_EX, rb(), rb(), 1'b0, 1'b0);
                cyc(P_ADDI_WB, rb(), rb(), 1'b0, 1'b1);
            end
            default: begin
                repeat (halt_len) cyc(P_HALT, rb(), rb(), 1'b0, 1'b0);
                cyc(P_HALT, rb(), rb(), 1'b1, 1'b0);
            end
        endcase
    endtask

    // Monitor: every cycle the DUT presents a full control word; compare it against the queued expectation.
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {state, pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, halted};
                n_chk++;
                if (a !== e.o || instr_retired !== e.ret) begin
                    n_fail++;
                    $display("FAIL ctl phase=%0d t=%0t: got ctl=%h retired=%h, want ctl=%h retired=%h",
                             e.ph, $time, a, instr_retired, e.o, e.ret);
                end
            end
        end
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[5];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        m_ret = '0;
        @(posedge clk);
        #1;

        // sw aborted by reset on its second write-wait cycle, with mem_ready high
        opcode = 6'h2B; funct = 6'h00;
        cyc(P_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(P_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(P_MEM_ADDR, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(P_MEM_WRITE, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(P_MEM_WRITE, 1'b1, 1'b0, 1'b1, 1'b0);

        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0);
        run_instr(6'h23, 6'h00, 1'b0, 0, 2, 0);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0, 0);
        run_instr(6'h04, 6'h00, 1'b0, 1, 0, 0);
        run_instr(6'h00, 6'h2A, 1'b0, 2, 0, 0);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 9);

        // counter wrap: preload all-ones during a fetch stall, then retire a jump
        opcode = 6'h02;
        force dut.r_instr_retired = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        cyc(P_FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        release dut.r_instr_retired;
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, 0);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            int r;
            logic [5:0] op, fn;
            r  = $urandom_range(0, 11);
            op = ops[$urandom_range(0, 5)];
            fn = (op == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            if (r == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else if (r == 1) begin
                op = 6'h00;
                fn = 6'($urandom);
            end
            run_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 4));
        end

        repeat (3) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
